// File: rtl/tile_row_packer_if.sv
// Handshake and tile-BRAM write bus for the tile row packer.
// master = configuration/data source side, slave = packer side.
interface tile_row_packer_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int TILE_ADDR_WIDTH = 10
);
    logic                       start;
    logic [5:0]                 row_len;
    logic [9:0]                 chan_num;
    logic [TILE_ADDR_WIDTH-1:0] base_addr_wr;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       data_valid;
    logic                       data_consumed;
    logic                       tile_wr_en;
    logic [TILE_ADDR_WIDTH-1:0] tile_wr_addr;
    logic [7:0]                 tile_wr_data;
    logic                       busy;
    logic                       done;

    modport master (
        output start, row_len, chan_num, base_addr_wr, in_data, data_valid,
        input  data_consumed, tile_wr_en, tile_wr_addr, tile_wr_data, busy, done
    );

    modport slave (
        input  start, row_len, chan_num, base_addr_wr, in_data, data_valid,
        output data_consumed, tile_wr_en, tile_wr_addr, tile_wr_data, busy, done
    );
endinterface

// File: rtl/tile_row_packer.sv
// Unpacks 64-bit feature-map words into bytes and writes them one per cycle
// into the tile BRAM, dropping the pad bytes at the end of every row.
module tile_row_packer #(
    parameter int DATA_WIDTH      = 64,
    parameter int TILE_ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    tile_row_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_r;
    logic [5:0]                 row_len_r;
    logic [9:0]                 chan_num_r;
    logic [TILE_ADDR_WIDTH-1:0] ptr_r;
    logic [DATA_WIDTH-1:0]      hold_r;
    logic [3:0]                 hold_cnt_r;
    logic [2:0]                 byte_idx_r;
    logic [2:0]                 word_cnt_r;
    logic [9:0]                 row_cnt_r;
    logic                       wr_en_r;
    logic [TILE_ADDR_WIDTH-1:0] wr_addr_r;
    logic [7:0]                 wr_data_r;
    logic                       busy_r;
    logic                       done_r;

    logic [3:0] wpr_s;
    logic       last_word_s;
    logic [3:0] last_bytes_s;
    logic [3:0] word_bytes_s;
    logic       words_left_s;
    logic       hold_free_s;
    logic       accept_s;

    // Per-word byte count and acceptance; a new word can load while the
    // final held byte is being emitted so full words stream without bubbles.
    always_comb begin
        wpr_s        = {1'b0, row_len_r[5:3]} + {3'b000, |row_len_r[2:0]};
        last_word_s  = ({1'b0, word_cnt_r} == (wpr_s - 4'd1));
        last_bytes_s = (row_len_r[2:0] == 3'd0) ? 4'd8 : {1'b0, row_len_r[2:0]};
        if (last_word_s) begin
            word_bytes_s = last_bytes_s;
        end else begin
            word_bytes_s = 4'd8;
        end
        words_left_s = (row_cnt_r < chan_num_r);
        hold_free_s  = (hold_cnt_r == 4'd0) || (hold_cnt_r == 4'd1);
        // A word offered alongside start/clr would be thrown away, so it is not acknowledged.
        accept_s     = (state_r == ST_RUN) && bus.data_valid && words_left_s &&
                       hold_free_s && !bus.start && !clr;
    end

    assign bus.data_consumed = accept_s;
    assign bus.tile_wr_en    = wr_en_r;
    assign bus.tile_wr_addr  = wr_addr_r;
    assign bus.tile_wr_data  = wr_data_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;

    // Control FSM, hold register, counters and registered BRAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            row_len_r  <= 6'd0;
            chan_num_r <= 10'd0;
            ptr_r      <= '0;
            hold_r     <= '0;
            hold_cnt_r <= 4'd0;
            byte_idx_r <= 3'd0;
            word_cnt_r <= 3'd0;
            row_cnt_r  <= 10'd0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (clr) begin
            state_r    <= ST_IDLE;
            row_len_r  <= 6'd0;
            chan_num_r <= 10'd0;
            ptr_r      <= '0;
            hold_r     <= '0;
            hold_cnt_r <= 4'd0;
            byte_idx_r <= 3'd0;
            word_cnt_r <= 3'd0;
            row_cnt_r  <= 10'd0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (bus.start) begin
            row_len_r  <= bus.row_len;
            chan_num_r <= bus.chan_num;
            ptr_r      <= bus.base_addr_wr;
            hold_cnt_r <= 4'd0;
            byte_idx_r <= 3'd0;
            word_cnt_r <= 3'd0;
            row_cnt_r  <= 10'd0;
            wr_en_r    <= 1'b0;
            if ((bus.row_len == 6'd0) || (bus.chan_num == 10'd0)) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
            end else begin
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
            end
        end else begin
            if (hold_cnt_r != 4'd0) begin
                wr_en_r    <= 1'b1;
                wr_addr_r  <= ptr_r;
                wr_data_r  <= hold_r[{byte_idx_r, 3'b000} +: 8];
                ptr_r      <= ptr_r + {{(TILE_ADDR_WIDTH-1){1'b0}}, 1'b1};
                byte_idx_r <= byte_idx_r + 3'd1;
                hold_cnt_r <= hold_cnt_r - 4'd1;
            end else begin
                wr_en_r <= 1'b0;
            end

            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        hold_r     <= bus.in_data;
                        hold_cnt_r <= word_bytes_s;
                        byte_idx_r <= 3'd0;
                        if (last_word_s) begin
                            word_cnt_r <= 3'd0;
                            row_cnt_r  <= row_cnt_r + 10'd1;
                        end else begin
                            word_cnt_r <= word_cnt_r + 3'd1;
                        end
                    end else if (!words_left_s && (hold_cnt_r == 4'd0)) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_row_packer.sv
// Directed self-checking bench for tile_row_packer.
module tb_tile_row_packer;

    logic clk;
    logic rst_n;
    logic clr;

    int tests_run;
    int tests_failed;

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int acc_q[$];
    int done_cyc;
    int busy_at_done;
    int extra_dc;
    int widx;

    tile_row_packer_if #(.DATA_WIDTH(64), .TILE_ADDR_WIDTH(10)) bus();

    tile_row_packer #(.DATA_WIDTH(64), .TILE_ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int w, input int i);
        logic [7:0] b;
        b = {w[4:0], i[2:0]};
        return b;
    endfunction

    function automatic logic [63:0] word_data(input int w);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = exp_byte(w, i);
        return d;
    endfunction

    // Expected byte for the n-th write of a tile with row length len, wpr words per row.
    function automatic int exp_wr_data(input int n, input int len, input int wpr);
        int r;
        int b;
        r = n / len;
        b = n % len;
        return int'(exp_byte(r * wpr + b / 8, b % 8));
    endfunction

    task automatic do_start(input int len, input int chans, input int base);
        bus.start        = 1'b1;
        bus.row_len      = len[5:0];
        bus.chan_num     = chans[9:0];
        bus.base_addr_wr = base[9:0];
        bus.data_valid   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Streams words cycle by cycle and records acks, writes and done timing.
    task automatic run_tile(input int toggle, input int stop_wr, input int max_cyc);
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); acc_q.delete();
        done_cyc = -1; busy_at_done = -1; extra_dc = 0; widx = 0;
        for (int c = 0; c < max_cyc; c++) begin
            bus.data_valid = (toggle != 0) ? ((c % 2) == 0) : 1'b1;
            bus.in_data    = word_data(widx);
            #1;
            if (bus.tile_wr_en) begin
                wr_addr_q.push_back(int'(bus.tile_wr_addr));
                wr_data_q.push_back(int'(bus.tile_wr_data));
                wr_cyc_q.push_back(c);
            end
            if (done_cyc < 0 && bus.done) begin
                done_cyc = c;
                busy_at_done = int'(bus.busy);
            end
            if (bus.data_consumed) begin
                if (done_cyc >= 0) extra_dc++;
                else begin
                    acc_q.push_back(c);
                    widx++;
                end
            end
            if (stop_wr > 0 && wr_addr_q.size() == stop_wr) break;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.data_valid = 1'b1;
        #1;
        tests_run++;
        if ({bus.tile_wr_en, bus.tile_wr_addr, bus.tile_wr_data, bus.busy, bus.done, bus.data_consumed} !== 22'd0) begin
            $display("FAIL reset_outputs: got en=%0b addr=%0h data=%0h busy=%0b done=%0b dc=%0b, expected all 0",
                     bus.tile_wr_en, bus.tile_wr_addr, bus.tile_wr_data, bus.busy, bus.done, bus.data_consumed);
            tests_failed++;
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic test_row18();
        int bad;
        do_start(18, 2, 16'h010);
        run_tile(0, 0, 200);
        tests_run++;
        if (acc_q.size() != 6) begin
            $display("FAIL row18_acks: got %0d expected 6", acc_q.size()); tests_failed++;
        end
        tests_run++;
        if (wr_addr_q.size() != 36) begin
            $display("FAIL row18_writes: got %0d expected 36", wr_addr_q.size()); tests_failed++;
        end
        bad = 0;
        for (int n = 0; n < wr_addr_q.size() && n < 36; n++) begin
            if (wr_addr_q[n] != 16 + n || wr_data_q[n] != exp_wr_data(n, 18, 3)) begin
                if (bad == 0)
                    $display("FAIL row18_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             n, wr_addr_q[n], wr_data_q[n], 16 + n, exp_wr_data(n, 18, 3));
                bad++;
            end
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (wr_cyc_q.size() == 0 || done_cyc != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
            $display("FAIL row18_done_timing: got done cycle %0d expected one after last write", done_cyc);
            tests_failed++;
        end
        tests_run++;
        if (busy_at_done != 0) begin
            $display("FAIL row18_busy_at_done: got %0d expected 0", busy_at_done); tests_failed++;
        end
        tests_run++;
        if (extra_dc != 0) begin
            $display("FAIL row18_extra_ack: got %0d expected 0", extra_dc); tests_failed++;
        end
    endtask

    task automatic test_stream_wrap();
        int bad;
        do_start(16, 3, 16'h3F0);
        run_tile(0, 0, 200);
        tests_run++;
        if (acc_q.size() != 6) begin
            $display("FAIL stream_acks: got %0d expected 6", acc_q.size()); tests_failed++;
        end
        bad = 0;
        for (int k = 0; k < acc_q.size(); k++) if (acc_q[k] != 8 * k) bad++;
        tests_run++;
        if (bad != 0) begin
            $display("FAIL stream_ack_spacing: got %0d misplaced acks expected 0", bad); tests_failed++;
        end
        tests_run++;
        if (wr_addr_q.size() != 48) begin
            $display("FAIL stream_writes: got %0d expected 48", wr_addr_q.size()); tests_failed++;
        end
        bad = 0;
        for (int n = 0; n < wr_addr_q.size() && n < 48; n++)
            if (wr_addr_q[n] != ((16'h3F0 + n) % 1024) || wr_cyc_q[n] != wr_cyc_q[0] + n ||
                wr_data_q[n] != exp_wr_data(n, 16, 2)) bad++;
        tests_run++;
        if (bad != 0) begin
            $display("FAIL stream_contiguous_wrap: got %0d bad writes expected 0", bad); tests_failed++;
        end
        tests_run++;
        if (wr_cyc_q.size() == 0 || acc_q.size() == 0 || wr_cyc_q[0] != acc_q[0] + 2) begin
            $display("FAIL stream_first_latency: got first write cycle %0d expected 2",
                     (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1);
            tests_failed++;
        end
    endtask

    task automatic test_toggle_valid();
        int bad;
        do_start(33, 1, 16'h040);
        run_tile(1, 0, 300);
        tests_run++;
        if (acc_q.size() != 5) begin
            $display("FAIL toggle_acks: got %0d expected 5", acc_q.size()); tests_failed++;
        end
        tests_run++;
        if (wr_addr_q.size() != 33) begin
            $display("FAIL toggle_writes: got %0d expected 33", wr_addr_q.size()); tests_failed++;
        end
        bad = 0;
        for (int n = 0; n < wr_addr_q.size() && n < 33; n++)
            if (wr_addr_q[n] != 16'h040 + n || wr_data_q[n] != exp_wr_data(n, 33, 5)) bad++;
        tests_run++;
        if (bad != 0) begin
            $display("FAIL toggle_order: got %0d bad writes expected 0", bad); tests_failed++;
        end
        tests_run++;
        if (wr_data_q.size() != 33 || wr_data_q[32] != int'(exp_byte(4, 0))) begin
            $display("FAIL toggle_last_byte: got %0h expected %0h",
                     (wr_data_q.size() > 0) ? wr_data_q[wr_data_q.size()-1] : -1, exp_byte(4, 0));
            tests_failed++;
        end
        tests_run++;
        if (done_cyc < 0) begin
            $display("FAIL toggle_done: got no done expected done"); tests_failed++;
        end
    endtask

    task automatic test_empty_tiles();
        int lens[2]  = '{0, 8};
        int chans[2] = '{5, 0};
        for (int t = 0; t < 2; t++) begin
            do_start(lens[t], chans[t], 16'h020);
            tests_run++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
                $display("FAIL empty%0d_done: got done=%0b busy=%0b expected done=1 busy=0", t, bus.done, bus.busy);
                tests_failed++;
            end
            run_tile(0, 0, 10);
            tests_run++;
            if (acc_q.size() + extra_dc + wr_addr_q.size() != 0) begin
                $display("FAIL empty%0d_activity: got %0d acks/writes expected 0", t,
                         acc_q.size() + extra_dc + wr_addr_q.size());
                tests_failed++;
            end
        end
    endtask

    task automatic test_clr_restart();
        int bad;
        do_start(18, 2, 16'h000);
        run_tile(0, 10, 100);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.data_valid = 1'b1;
        #1;
        tests_run++;
        if ({bus.tile_wr_en, bus.tile_wr_addr, bus.tile_wr_data, bus.busy, bus.done, bus.data_consumed} !== 22'd0) begin
            $display("FAIL clr_outputs: got en=%0b addr=%0h data=%0h busy=%0b done=%0b dc=%0b, expected all 0",
                     bus.tile_wr_en, bus.tile_wr_addr, bus.tile_wr_data, bus.busy, bus.done, bus.data_consumed);
            tests_failed++;
        end
        do_start(8, 1, 16'h100);
        run_tile(0, 0, 60);
        bad = 0;
        for (int n = 0; n < wr_addr_q.size(); n++)
            if (wr_addr_q[n] != 16'h100 + n || wr_data_q[n] != int'(exp_byte(0, n))) bad++;
        tests_run++;
        if (wr_addr_q.size() != 8 || bad != 0) begin
            $display("FAIL clr_restart: got %0d writes (%0d bad) expected 8 at 0x100", wr_addr_q.size(), bad);
            tests_failed++;
        end
    endtask

    task automatic test_async_reset();
        int seen;
        do_start(16, 1, 16'h080);
        run_tile(0, 1, 40);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.tile_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL async_reset_drop: got en=%0b busy=%0b expected 0 0", bus.tile_wr_en, bus.busy);
            tests_failed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            bus.data_valid = 1'b1;
            @(posedge clk); #1;
            if (bus.tile_wr_en || bus.data_consumed || bus.busy || bus.done) seen++;
        end
        bus.data_valid = 1'b0;
        tests_run++;
        if (seen != 0) begin
            $display("FAIL async_reset_quiet: got %0d active cycles expected 0", seen); tests_failed++;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        bus.start = 1'b0;
        bus.row_len = 6'd0;
        bus.chan_num = 10'd0;
        bus.base_addr_wr = 10'd0;
        bus.in_data = 64'd0;
        bus.data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_row18();
        test_stream_wrap();
        test_toggle_valid();
        test_empty_tiles();
        test_clr_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
